// File: rtl/pc_sequencer.sv
// Program-counter stage of the single-cycle MIPS core.
// Registers the next PC from branch control, runs the HALT / single-step
// protocol driven by a synchronised OK button, and counts committed
// instructions.
module pc_sequencer #(
  parameter int unsigned          PC_W     = 11,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             halt,
  input  logic             ok,
  input  logic             imem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             commit,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ok_s1;
  logic              ok_s2;
  logic              ok_d;
  logic              ok_rise;
  logic              commit_raw;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic              halted_q;

  // Two-flop synchroniser for the asynchronous button, plus one delay for edge detection.
  // NOTE: every sequential assignment is non-blocking so all flops sample
  // pre-edge values; a blocking '=' here would collapse the chain into a wire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ok_s1 <= 1'b0;
      ok_s2 <= 1'b0;
      ok_d  <= 1'b0;
    end else begin
      ok_s1 <= ok;
      ok_s2 <= ok_s1;
      ok_d  <= ok_s2;
    end
  end

  // One pulse per button press, only ever derived from the synchronised copy.
  assign ok_rise = ok_s2 & ~ok_d;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and commit decode.
  // NOTE: defaults are assigned before the case so every path drives every
  // signal; missing one would infer a latch.
  always_comb begin
    state_d    = state_q;
    commit_raw = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A stall masks halt: the instruction word is not valid yet.
        if (imem_ready) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            commit_raw = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        // The press steps over the HALT; branch control presents PC+1.
        if (ok_rise) begin
          commit_raw = 1'b1;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the button to be let go so one press gives one step.
        if (!ok_s2) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Nothing commits while reset is held, even though the FSM decodes RUN.
  assign commit = commit_raw & reset_n;

  // PC register: follows branch control only on committing cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (commit_raw) begin
      pc_q <= next_pc;
    end
  end

  // Retired-instruction counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (commit_raw) begin
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered halted flag: high whenever the FSM is about to sit outside RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= (state_d != ST_RUN);
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stall, halt/step, held button,
// PC wrap, counter wrap (narrow-counter instance) and reset during RELEASE.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] next_pc;
  logic        halt;
  logic        ok;
  logic        imem_ready;
  logic [10:0] pc;
  logic        commit;
  logic        halted;
  logic [15:0] retired;

  logic [10:0] pc_s;
  logic        commit_s;
  logic        halted_s;
  logic [3:0]  retired_s;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_sequencer u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .next_pc    (next_pc),
    .halt       (halt),
    .ok         (ok),
    .imem_ready (imem_ready),
    .pc         (pc),
    .commit     (commit),
    .halted     (halted),
    .retired    (retired)
  );

  // Narrow-counter copy used to reach the counter wrap quickly.
  pc_sequencer #(.CNT_W(4)) u_small (
    .clock      (clock),
    .reset_n    (reset_n),
    .next_pc    (next_pc),
    .halt       (halt),
    .ok         (ok),
    .imem_ready (imem_ready),
    .pc         (pc_s),
    .commit     (commit_s),
    .halted     (halted_s),
    .retired    (retired_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 2 time units past the last one.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    reset_n    = 1'b0;
    next_pc    = 11'h123;
    imem_ready = 1'b1;
    halt       = 1'b0;
    ok         = 1'b0;
    #1;
    check("rst pc", 32'(pc), 32'h000);
    check("rst retired", 32'(retired), 32'h0);
    check("rst halted", 32'(halted), 32'h0);
    check("rst commit", 32'(commit), 32'h0);
    cyc(3);
    check("rst hold pc", 32'(pc), 32'h000);
    check("rst hold retired", 32'(retired), 32'h0);
    check("rst hold halted", 32'(halted), 32'h0);

    reset_n = 1'b1;
    #1;
    check("post rst commit", 32'(commit), 32'h1);
    cyc();
    check("first pc", 32'(pc), 32'h123);
    check("first retired", 32'(retired), 32'h1);

    // Stall
    next_pc = 11'h010;
    cyc();
    check("pc 010", 32'(pc), 32'h010);
    check("retired 2", 32'(retired), 32'h2);
    imem_ready = 1'b0;
    next_pc    = 11'h011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall commit", 32'(commit), 32'h0);
      cyc();
      check("stall pc", 32'(pc), 32'h010);
    end
    imem_ready = 1'b1;
    #1;
    check("unstall commit", 32'(commit), 32'h1);
    cyc();
    check("unstall pc", 32'(pc), 32'h011);
    check("retired 3", 32'(retired), 32'h3);

    // Stall masks halt
    imem_ready = 1'b0;
    halt       = 1'b1;
    #1;
    check("mask commit", 32'(commit), 32'h0);
    cyc();
    check("mask halted", 32'(halted), 32'h0);
    check("mask pc", 32'(pc), 32'h011);
    imem_ready = 1'b1;
    halt       = 1'b0;

    // Halt and single step
    next_pc = 11'h020;
    cyc();
    check("pc 020", 32'(pc), 32'h020);
    halt    = 1'b1;
    next_pc = 11'h021;
    #1;
    check("halt commit", 32'(commit), 32'h0);
    cyc();
    check("halt rises", 32'(halted), 32'h1);
    check("halt pc", 32'(pc), 32'h020);
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("halted pc", 32'(pc), 32'h020);
      check("halted retired", 32'(retired), 32'h4);
      check("halted commit", 32'(commit), 32'h0);
    end
    ok = 1'b1;
    #1;
    check("ok pre commit", 32'(commit), 32'h0);
    cyc();
    check("ok e0 commit", 32'(commit), 32'h0);
    cyc();
    check("ok e1 commit", 32'(commit), 32'h1);
    check("ok e1 pc", 32'(pc), 32'h020);
    cyc();
    check("step pc", 32'(pc), 32'h021);
    check("step retired", 32'(retired), 32'h5);
    check("step commit", 32'(commit), 32'h0);
    check("step halted", 32'(halted), 32'h1);
    halt    = 1'b0;
    next_pc = 11'h022;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("release commit", 32'(commit), 32'h0);
      check("release halted", 32'(halted), 32'h1);
      check("release pc", 32'(pc), 32'h021);
    end
    ok = 1'b0;
    cyc();
    check("drop e5 halted", 32'(halted), 32'h1);
    check("drop e5 commit", 32'(commit), 32'h0);
    cyc();
    check("drop e6 halted", 32'(halted), 32'h1);
    check("drop e6 commit", 32'(commit), 32'h0);
    cyc();
    check("drop e7 halted", 32'(halted), 32'h0);
    check("drop e7 pc", 32'(pc), 32'h021);
    check("drop e7 retired", 32'(retired), 32'h5);
    check("drop e7 commit", 32'(commit), 32'h1);
    cyc();
    check("resume pc", 32'(pc), 32'h022);
    check("resume retired", 32'(retired), 32'h6);

    // OK already high on entry to HALTED
    ok      = 1'b1;
    next_pc = 11'h030;
    cyc(3);
    check("okh run pc", 32'(pc), 32'h030);
    check("okh run retired", 32'(retired), 32'h9);
    check("okh run halted", 32'(halted), 32'h0);
    halt    = 1'b1;
    next_pc = 11'h031;
    cyc();
    check("okh halted", 32'(halted), 32'h1);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("okh held commit", 32'(commit), 32'h0);
      cyc();
      check("okh held pc", 32'(pc), 32'h030);
    end
    ok = 1'b0;
    cyc(3);
    check("okh low pc", 32'(pc), 32'h030);
    ok = 1'b1;
    cyc(2);
    check("okh rise commit", 32'(commit), 32'h1);
    cyc();
    check("okh step pc", 32'(pc), 32'h031);
    check("okh step retired", 32'(retired), 32'hA);
    ok      = 1'b0;
    halt    = 1'b0;
    next_pc = 11'h032;
    cyc(3);
    check("okh back halted", 32'(halted), 32'h0);
    check("okh back pc", 32'(pc), 32'h031);

    // PC wrap
    next_pc = 11'h7FF;
    cyc();
    check("wrap pc 7ff", 32'(pc), 32'h7FF);
    next_pc = 11'h000;
    cyc();
    check("wrap pc 000", 32'(pc), 32'h000);
    check("wrap retired", 32'(retired), 32'hC);

    // Reset while in RELEASE with ok held
    next_pc = 11'h050;
    halt    = 1'b1;
    cyc();
    check("rr halted", 32'(halted), 32'h1);
    ok = 1'b1;
    cyc(3);
    check("rr step pc", 32'(pc), 32'h050);
    check("rr in release", 32'(halted), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr async pc", 32'(pc), 32'h000);
    check("rr async halted", 32'(halted), 32'h0);
    check("rr async retired", 32'(retired), 32'h0);
    check("rr async commit", 32'(commit), 32'h0);
    halt = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      next_pc = 11'(11'h100 + i);
      cyc();
      check("rr run pc", 32'(pc), 32'(11'h100 + i));
      check("rr run retired", 32'(retired), 32'(i + 1));
      check("rr run halted", 32'(halted), 32'h0);
      if (i == 14) check("cnt 0xF", 32'(retired_s), 32'hF);
    end
    check("cnt wrap", 32'(retired_s), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the single-cycle MIPS core. It registers the 11-bit next-PC produced combinationally by the branch control block and feeds the registered PC back to branch control and to instruction memory. It owns the HALT/step-over protocol: a synchronised, edge-detected OK button releases a halted core, and it emits a per-instruction commit enable plus a retired-instruction counter.

## Interface

Parameters:
- PC_W, 11: PC width; must match branch control.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- next_pc  in  PC_W  next PC from branch control.
- halt  in  1  decoded HALT of the current instruction.
- ok  in  1  asynchronous OK/step button, active-high.
- imem_ready  in  1  instruction word at pc is valid this cycle.
- pc  out  PC_W  registered PC.
- commit  out  1  the current instruction commits this cycle; gates register-file and data-memory writes.
- halted  out  1  high in HALTED and RELEASE.
- retired  out  CNT_W  count of committed instructions.

## Operation

- OK synchroniser: ok passes through two flops (ok_s1, then ok_s2), and ok_s2 is delayed once more to give ok_d. The rising-edge pulse is ok_rise = ok_s2 & ~ok_d.
- The FSM has three states: RUN, HALTED and RELEASE.
- RUN:
  - imem_ready=0: stall. pc holds, commit=0, and halt is ignored.
  - imem_ready=1 and halt=0: commit=1, pc <= next_pc, retired += 1. Stay in RUN.
  - imem_ready=1 and halt=1: commit=0 and pc holds. Go to HALTED.
- HALTED:
  - pc holds and commit=0 until ok_rise.
  - On ok_rise: commit=1, pc <= next_pc (branch control supplies PC+1 here), retired += 1. Go to RELEASE.
- RELEASE:
  - pc holds and commit=0 while ok_s2=1.
  - When ok_s2=0, go to RUN. No instruction commits on that transition cycle.
  - This guarantees exactly one step per press.
- commit is combinational from state, imem_ready, halt and ok_rise. pc, halted and retired are registered.
- Arithmetic:
  - pc is exactly PC_W bits and takes whatever next_pc presents. Wrap from 0x7FF to 0x000 happens upstream and is accepted unchanged.
  - retired wraps modulo 2^CNT_W, with no saturation.
- Asserting reset_n=0 at any time, including in HALTED or RELEASE or mid-stall, does the following immediately:
  - pc = RESET_PC, state = RUN, retired = 0;
  - ok_s1, ok_s2 and ok_d all cleared.
  - An ok held high through the end of reset produces an ok_rise 2 cycles after release. This is ignored because the FSM is in RUN.

## Timing

- Reset values: pc=RESET_PC, commit=0, halted=0, retired=0.
- commit is valid combinationally in the same cycle as its qualifying inputs.
- On the rising edge that ends a commit=1 cycle:
  - pc takes next_pc;
  - retired increments.
- halted is registered:
  - it rises on the edge that ends the halt=1, imem_ready=1 cycle;
  - it falls on the edge that moves RELEASE to RUN.
- OK latency:
  - ok_rise is asserted in the 2nd cycle after ok is sampled high at a rising edge, counting that edge as cycle 0.
  - pc advances on the rising edge at the end of that cycle.
- ok is already high on entry to HALTED:
  - No ok_rise can occur until ok goes low and then high again.
  - The core stays halted until then.
- Simultaneous events:
  - In RUN, an imem_ready stall masks halt.
  - ok_rise is only acted on in HALTED; in RUN and RELEASE it is ignored.
- There are no combinational paths from ok to any output except through the synchroniser.

## Test plan

- Reset:
  - Hold reset_n=0 with next_pc=0x123 and imem_ready=1: pc=0x000, retired=0 and halted=0 throughout.
  - After release, the first rising edge gives pc=0x123 and retired=1.
- Stall:
  - In RUN with pc=0x010, next_pc=0x011 and imem_ready low for 3 cycles, pc stays at 0x010 and commit=0.
  - On the first cycle imem_ready=1, commit=1 and the next edge gives pc=0x011.
- Halt and single step:
  - At pc=0x020, assert halt=1 with next_pc=0x021: halted=1, pc stays 0x020 for 10 cycles and retired does not change.
  - Pulse ok high for 5 cycles: exactly one commit, 3 cycles after ok is first sampled high; pc=0x021 and retired increments by 1.
  - halted drops 3 cycles after ok returns low.
- OK held:
  - With ok already high when HALTED is entered, pc does not advance.
  - Drop ok, then raise it again: pc advances once.
- Wrap:
  - next_pc=0x000 from pc=0x7FF: pc=0x000.
  - Preload retired to 0xFFFF and commit once: retired=0x0000.
- Reset in RELEASE:
  - Assert reset_n=0 while in RELEASE with ok high: pc=RESET_PC and halted=0 asynchronously.
  - After reset_n is released with ok still high, the core runs normally and no extra step occurs.
